// File: rtl/countdown_timer.sv
// Countdown timer: preset MM:SS with three keys, count down MM:SS:CC in
// 10 ms steps, alarm at 00:00:00. Six active-low 7-seg digits show the count.

// Active-low 7-seg decoder, segment order {g,f,e,d,c,b,a}; non-BCD input blanks
module sevenseg (
  input  logic [3:0] i_digit,
  output logic [6:0] o_seg
);

  // Pure lookup from one BCD digit to its segment pattern
  always_comb begin
    o_seg = 7'b111_1111;
    case (i_digit)
      4'd0: o_seg = 7'b100_0000;
      4'd1: o_seg = 7'b111_1001;
      4'd2: o_seg = 7'b010_0100;
      4'd3: o_seg = 7'b011_0000;
      4'd4: o_seg = 7'b001_1001;
      4'd5: o_seg = 7'b001_0010;
      4'd6: o_seg = 7'b000_0010;
      4'd7: o_seg = 7'b111_1000;
      4'd8: o_seg = 7'b000_0000;
      4'd9: o_seg = 7'b001_0000;
      default: o_seg = 7'b111_1111;
    endcase
  end

endmodule

// Press detector for one active-low key: a release only counts as a press
// when the key was held low for at least DEBOUNCE_CYCLES clocks
module KeyDebounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_key,
  output logic o_event
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(DEBOUNCE_CYCLES);

  logic [CW-1:0] r_lowCnt;

  // Saturating low-time counter, cleared on the first cycle the key is high
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_lowCnt <= '0;
    end else if (!i_key) begin
      if (r_lowCnt != LIMIT) r_lowCnt <= r_lowCnt + 1'b1;
    end else begin
      r_lowCnt <= '0;
    end
  end

  // The pulse is only one cycle wide because the counter clears on that same edge
  assign o_event = i_key && (r_lowCnt >= LIMIT);

endmodule

module countdown_timer #(
  parameter int TICK_CYCLES     = 500000,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_key_set,
  input  logic       i_key_start_pause,
  input  logic       i_key_inc,
  output logic [6:0] o_hex0,
  output logic [6:0] o_hex1,
  output logic [6:0] o_hex2,
  output logic [6:0] o_hex3,
  output logic [6:0] o_hex4,
  output logic [6:0] o_hex5,
  output logic       o_led_run,
  output logic       o_led_sel_min,
  output logic       o_led_alarm
);

  localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_SET,
    ST_RUN,
    ST_PAUSE,
    ST_ALARM
  } state_t;

  state_t        r_state;
  state_t        w_nextState;
  logic          r_selMin;
  logic [15:0]   r_preset;
  logic [23:0]   r_count;
  logic [TW-1:0] r_tickCnt;

  logic          w_rawSet, w_rawStart, w_rawInc;
  logic          w_setEv, w_startEv, w_incEv, w_anyEv;
  logic          w_presetNonZero;
  logic          w_tickWrap;
  logic [23:0]   w_decCount;
  logic          w_decZero;
  logic [23:0]   w_disp;

  // Adds one to a two-digit field (high 0-5, low 0-9), 59 wraps to 00
  function automatic logic [7:0] bcdInc60(input logic [7:0] v);
    logic [7:0] res;
    res = v;
    if (v[3:0] == 4'd9) begin
      res[3:0] = 4'd0;
      res[7:4] = (v[7:4] == 4'd5) ? 4'd0 : v[7:4] + 4'd1;
    end else begin
      res[3:0] = v[3:0] + 4'd1;
    end
    return res;
  endfunction

  KeyDebounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) uDbSet (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_key(i_key_set), .o_event(w_rawSet));
  KeyDebounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) uDbStart (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_key(i_key_start_pause), .o_event(w_rawStart));
  KeyDebounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) uDbInc (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_key(i_key_inc), .o_event(w_rawInc));

  // Coincident presses: set wins over start/pause, which wins over inc
  assign w_setEv   = w_rawSet;
  assign w_startEv = w_rawStart & ~w_rawSet;
  assign w_incEv   = w_rawInc & ~w_rawSet & ~w_rawStart;
  assign w_anyEv   = w_setEv | w_startEv | w_incEv;

  assign w_presetNonZero = (r_preset != 16'h0000);
  assign w_tickWrap      = (r_tickCnt == TICK_LAST);

  // One-centisecond BCD decrement with borrow chain CC -> seconds -> minutes
  always_comb begin
    w_decCount = r_count;
    if (r_count[3:0] != 4'd0) begin
      w_decCount[3:0] = r_count[3:0] - 4'd1;
    end else begin
      w_decCount[3:0] = 4'd9;
      if (r_count[7:4] != 4'd0) begin
        w_decCount[7:4] = r_count[7:4] - 4'd1;
      end else begin
        w_decCount[7:4] = 4'd9;
        if (r_count[11:8] != 4'd0) begin
          w_decCount[11:8] = r_count[11:8] - 4'd1;
        end else begin
          w_decCount[11:8] = 4'd9;
          if (r_count[15:12] != 4'd0) begin
            w_decCount[15:12] = r_count[15:12] - 4'd1;
          end else begin
            w_decCount[15:12] = 4'd5;
            if (r_count[19:16] != 4'd0) begin
              w_decCount[19:16] = r_count[19:16] - 4'd1;
            end else begin
              w_decCount[19:16] = 4'd9;
              w_decCount[23:20] = (r_count[23:20] != 4'd0) ? r_count[23:20] - 4'd1 : 4'd5;
            end
          end
        end
      end
    end
    w_decZero = (w_decCount == 24'h000000);
  end

  // State register
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) r_state <= ST_SET;
    else            r_state <= w_nextState;
  end

  // Next-state decode and status LEDs
  always_comb begin
    w_nextState   = r_state;
    o_led_run     = 1'b0;
    o_led_sel_min = 1'b0;
    o_led_alarm   = 1'b0;
    case (r_state)
      ST_SET: begin
        o_led_sel_min = r_selMin;
        if (!w_setEv && w_startEv && w_presetNonZero) w_nextState = ST_RUN;
      end
      ST_RUN: begin
        o_led_run = 1'b1;
        if (w_startEv)                   w_nextState = ST_PAUSE;
        else if (w_tickWrap && w_decZero) w_nextState = ST_ALARM;
      end
      ST_PAUSE: begin
        if (w_setEv)        w_nextState = ST_SET;
        else if (w_startEv) w_nextState = ST_RUN;
      end
      ST_ALARM: begin
        o_led_alarm = 1'b1;
        if (w_anyEv) w_nextState = ST_SET;
      end
      default: w_nextState = ST_SET;
    endcase
  end

  // Field select and preset editing, only live while setting up
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_selMin <= 1'b0;
      r_preset <= 16'h0000;
    end else if (r_state == ST_SET) begin
      if (w_setEv) begin
        r_selMin <= ~r_selMin;
      end else if (w_incEv) begin
        if (r_selMin) r_preset[15:8] <= bcdInc60(r_preset[15:8]);
        else          r_preset[7:0]  <= bcdInc60(r_preset[7:0]);
      end
    end
  end

  // Count and tick divider; a start/pause event freezes the tick on its own edge
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_count   <= 24'h000000;
      r_tickCnt <= '0;
    end else begin
      case (r_state)
        ST_SET: begin
          r_tickCnt <= '0;
          if (!w_setEv && w_startEv && w_presetNonZero) r_count <= {r_preset, 8'h00};
        end
        ST_RUN: begin
          if (!w_startEv) begin
            if (w_tickWrap) begin
              r_tickCnt <= '0;
              r_count   <= w_decCount;
            end else begin
              r_tickCnt <= r_tickCnt + 1'b1;
            end
          end
        end
        ST_PAUSE: begin
          if (w_setEv) begin
            r_tickCnt <= '0;
            r_count   <= {r_preset, 8'h00};
          end
        end
        ST_ALARM: begin
          r_tickCnt <= '0;
          if (w_anyEv) r_count <= {r_preset, 8'h00};
        end
        default: r_tickCnt <= '0;
      endcase
    end
  end

  // While setting up the digits show the preset directly so edits appear at once
  assign w_disp = (r_state == ST_SET) ? {r_preset, 8'h00} : r_count;

  sevenseg uSeg5 (.i_digit(w_disp[23:20]), .o_seg(o_hex5));
  sevenseg uSeg4 (.i_digit(w_disp[19:16]), .o_seg(o_hex4));
  sevenseg uSeg3 (.i_digit(w_disp[15:12]), .o_seg(o_hex3));
  sevenseg uSeg2 (.i_digit(w_disp[11:8]),  .o_seg(o_hex2));
  sevenseg uSeg1 (.i_digit(w_disp[7:4]),   .o_seg(o_hex1));
  sevenseg uSeg0 (.i_digit(w_disp[3:0]),   .o_seg(o_hex0));

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer with short tick and debounce periods.
// Expected display/LED states are queued when a step is driven and popped
// when the DUT outputs are sampled on the falling clock edge.
module tb_countdown_timer;

  logic       clk;
  logic       resetN;
  logic       keySet, keyStart, keyInc;
  logic [6:0] hex0, hex1, hex2, hex3, hex4, hex5;
  logic       ledRun, ledSelMin, ledAlarm;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       tag;
    logic [41:0] hexAll;
    logic [2:0]  leds;
  } exp_t;

  exp_t sb[$];

  countdown_timer #(.TICK_CYCLES(4), .DEBOUNCE_CYCLES(3)) dut (
    .i_clk(clk), .i_reset_n(resetN),
    .i_key_set(keySet), .i_key_start_pause(keyStart), .i_key_inc(keyInc),
    .o_hex0(hex0), .o_hex1(hex1), .o_hex2(hex2),
    .o_hex3(hex3), .o_hex4(hex4), .o_hex5(hex5),
    .o_led_run(ledRun), .o_led_sel_min(ledSelMin), .o_led_alarm(ledAlarm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference segment table, active-low {g,f,e,d,c,b,a}
  function automatic logic [6:0] segOf(input int d);
    case (d)
      0: return 7'b100_0000;
      1: return 7'b111_1001;
      2: return 7'b010_0100;
      3: return 7'b011_0000;
      4: return 7'b001_1001;
      5: return 7'b001_0010;
      6: return 7'b000_0010;
      7: return 7'b111_1000;
      8: return 7'b000_0000;
      9: return 7'b001_0000;
      default: return 7'b111_1111;
    endcase
  endfunction

  // Model: time kept as total centiseconds, split into six display digits
  function automatic logic [41:0] hexFromCs(input int cs);
    int mm, ss, cc;
    mm = cs / 6000;
    ss = (cs / 100) % 60;
    cc = cs % 100;
    return {segOf(mm / 10), segOf(mm % 10), segOf(ss / 10),
            segOf(ss % 10), segOf(cc / 10), segOf(cc % 10)};
  endfunction

  function automatic int mmss(input int m, input int s);
    return m * 6000 + s * 100;
  endfunction

  // Queue an expected display value (centiseconds) and LEDs {run, selMin, alarm}
  task automatic expectState(input string tag, input int cs, input logic [2:0] leds);
    exp_t e;
    e.tag    = tag;
    e.hexAll = hexFromCs(cs);
    e.leds   = leds;
    sb.push_back(e);
  endtask

  // Pop the oldest expectation and compare it with the current DUT outputs
  task automatic checkOutput();
    exp_t        e;
    logic [41:0] obsHex;
    logic [2:0]  obsLeds;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("[TB] FAIL scoreboard_empty observed=0 expected=1");
      return;
    end
    e       = sb.pop_front();
    obsHex  = {hex5, hex4, hex3, hex2, hex1, hex0};
    obsLeds = {ledRun, ledSelMin, ledAlarm};
    total++;
    assert (obsHex === e.hexAll) else begin
      bad++;
      $error("[TB] FAIL %s hex observed=%h expected=%h", e.tag, obsHex, e.hexAll);
    end
    total++;
    assert (obsLeds === e.leds) else begin
      bad++;
      $error("[TB] FAIL %s leds observed=%b expected=%b", e.tag, obsLeds, e.leds);
    end
  endtask

  // Called on a falling edge: hold keys {set,start,inc} low for holdCycles
  // rising edges, release, and return on the falling edge after the edge
  // where the release acts
  task automatic applyStimulus(input logic [2:0] keyMask, input int holdCycles);
    if (keyMask[2]) keySet   = 1'b0;
    if (keyMask[1]) keyStart = 1'b0;
    if (keyMask[0]) keyInc   = 1'b0;
    repeat (holdCycles) @(negedge clk);
    keySet   = 1'b1;
    keyStart = 1'b1;
    keyInc   = 1'b1;
    @(negedge clk);
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Asynchronous reset pulse between falling edges, checked while held
  task automatic resetPulse(input string tag);
    #1 resetN = 1'b0;
    #2;
    expectState({tag, "_held"}, 0, 3'b000);
    checkOutput();
    @(negedge clk);
    resetN = 1'b1;
    @(negedge clk);
    expectState({tag, "_after"}, 0, 3'b000);
    checkOutput();
  endtask

  localparam logic [2:0] K_SET   = 3'b100;
  localparam logic [2:0] K_START = 3'b010;
  localparam logic [2:0] K_INC   = 3'b001;

  initial begin
    resetN   = 1'b0;
    keySet   = 1'b1;
    keyStart = 1'b1;
    keyInc   = 1'b1;
    waitCycles(3);
    resetN = 1'b1;
    @(negedge clk);
    expectState("reset", 0, 3'b000);
    checkOutput();

    // Too-short press is ignored
    applyStimulus(K_INC, 2);
    expectState("short_press", 0, 3'b000);
    checkOutput();

    // Seconds field increments
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(K_INC, 3);
      expectState($sformatf("inc_sec_%0d", i), mmss(0, i), 3'b000);
      checkOutput();
    end

    applyStimulus(K_SET, 3);
    expectState("sel_min", mmss(0, 5), 3'b010);
    checkOutput();

    applyStimulus(K_INC, 3);
    applyStimulus(K_INC, 3);
    expectState("inc_min_x2", mmss(2, 5), 3'b010);
    checkOutput();

    applyStimulus(K_SET, 3);
    expectState("sel_sec", mmss(2, 5), 3'b000);
    checkOutput();

    for (int i = 0; i < 54; i++) applyStimulus(K_INC, 3);
    expectState("sec_59", mmss(2, 59), 3'b000);
    checkOutput();

    applyStimulus(K_INC, 3);
    expectState("sec_wrap", mmss(2, 0), 3'b000);
    checkOutput();

    // Run, then pause with tick_cnt at 2
    applyStimulus(K_START, 3);
    expectState("run_start", mmss(2, 0), 3'b100);
    checkOutput();

    waitCycles(4);
    expectState("run_first_dec", mmss(2, 0) - 1, 3'b100);
    checkOutput();

    waitCycles(3);
    applyStimulus(K_START, 3);
    expectState("pause", mmss(2, 0) - 2, 3'b000);
    checkOutput();

    waitCycles(20);
    expectState("pause_frozen", mmss(2, 0) - 2, 3'b000);
    checkOutput();

    applyStimulus(K_START, 3);
    expectState("resume", mmss(2, 0) - 2, 3'b100);
    checkOutput();

    waitCycles(1);
    expectState("resume_plus1", mmss(2, 0) - 2, 3'b100);
    checkOutput();

    waitCycles(1);
    expectState("resume_plus2", mmss(2, 0) - 3, 3'b100);
    checkOutput();

    // Reset in the middle of a run
    resetPulse("reset_mid_run");

    // Countdown from 00:01:00 to the alarm
    applyStimulus(K_INC, 3);
    expectState("preset_1s", mmss(0, 1), 3'b000);
    checkOutput();

    applyStimulus(K_START, 3);
    expectState("run_1s", mmss(0, 1), 3'b100);
    checkOutput();

    waitCycles(4);
    expectState("run_99", 99, 3'b100);
    checkOutput();

    waitCycles(395);
    expectState("run_last_cc", 1, 3'b100);
    checkOutput();

    waitCycles(1);
    expectState("alarm", 0, 3'b001);
    checkOutput();

    waitCycles(5);
    expectState("alarm_hold", 0, 3'b001);
    checkOutput();

    applyStimulus(K_INC, 3);
    expectState("alarm_exit", mmss(0, 1), 3'b000);
    checkOutput();

    // Pause then abort back to the preset
    applyStimulus(K_START, 3);
    expectState("run_again", mmss(0, 1), 3'b100);
    checkOutput();

    applyStimulus(K_START, 4);
    expectState("pause_again", 99, 3'b000);
    checkOutput();

    applyStimulus(K_SET, 3);
    expectState("abort_to_set", mmss(0, 1), 3'b000);
    checkOutput();

    // Zero preset cannot start
    resetPulse("reset_in_set");

    applyStimulus(K_START, 3);
    expectState("start_zero", 0, 3'b000);
    checkOutput();

    waitCycles(5);
    expectState("start_zero_hold", 0, 3'b000);
    checkOutput();

    // Coincident set and inc: only the field toggles
    applyStimulus(K_SET | K_INC, 3);
    expectState("set_inc_same", 0, 3'b010);
    checkOutput();

    applyStimulus(K_INC, 3);
    expectState("inc_min_after", mmss(1, 0), 3'b010);
    checkOutput();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
